memory_port_arbiter: RTL and testbench
======================================

Name: memory_port_arbiter

Overview:
- Shares the core's single external memory port between instruction fetch (I side) and data load/store (D side).
- Runs one transaction at a time through an Avalon-style master: waitrequest plus readdatavalid.
- Returns completion pulses and hold levels that feed the pipeline flow-control (hold) logic.
- D has priority; a starvation counter guarantees I forward progress.

Parameters:
- STARVE_LIMIT, 4, maximum consecutive D grants while I is waiting; the next grant then goes to I (range 1..15).

Ports:
- clock  in  1  core clock
- reset_n  in  1  synchronous, active-low reset
- i_req  in  1  fetch request level; held until i_done
- i_address  in  32  fetch word address; stable while i_req
- i_cancel  in  1  pulse: abandon the in-flight or pending fetch (pc change)
- i_hold  out  1  fetch must stall
- i_done  out  1  one-cycle pulse: i_rdata valid
- i_rdata  out  32  fetched instruction
- d_req  in  1  data request level; held until d_done
- d_write  in  1  1 = store, 0 = load; stable while d_req
- d_address  in  32  data address
- d_wdata  in  32  store data
- d_hold  out  1  data stage must stall
- d_done  out  1  one-cycle pulse: load data valid, or store accepted
- d_rdata  out  32  load data
- mem_read  out  1  master read strobe
- mem_write  out  1  master write strobe
- mem_address  out  32  master address
- mem_writedata  out  32  master write data
- mem_waitrequest  in  1  slave not accepting
- mem_readdata  in  32  slave read data
- mem_readdatavalid  in  1  slave read data valid

Behaviour:
- Reset (reset_n low at a clock edge): state IDLE, starve counter 0, cancel flag 0. All outputs 0, except i_hold = i_req and d_hold = d_req (combinational).
- States:
  - IDLE: arbitrate.
  - ISSUE: strobe asserted.
  - WAIT_READ: read accepted, awaiting data.
  - DONE: one-cycle completion.
- IDLE:
  - If d_req and (not i_req or counter < STARVE_LIMIT): grant D. Counter increments if i_req, else clears.
  - Else if i_req and not i_cancel: grant I; counter clears.
  - On grant: register owner, address, write flag and wdata. Next state ISSUE; the strobe is high from the next cycle.
- ISSUE:
  - mem_read (load or fetch) or mem_write (store) is asserted.
  - mem_address and mem_writedata are held until the first cycle with mem_waitrequest low.
  - On that cycle: store -> DONE; read -> WAIT_READ. Strobes deassert on the following cycle.
- WAIT_READ:
  - On mem_readdatavalid, capture mem_readdata into the owner's rdata register -> DONE.
  - mem_readdatavalid in any other state is ignored.
- DONE:
  - Owner's done pulses for exactly this cycle.
  - Suppressed if the owner is I and the cancel flag is set.
  - Cancel flag clears; next state IDLE.
  - No grant is made in DONE, so a requester still showing req while seeing done is never re-granted.
- i_cancel:
  - Owner I in ISSUE or WAIT_READ: set the cancel flag. The transaction still runs to completion; the memory side is never truncated.
  - In IDLE: suppresses an I grant that cycle.
  - Otherwise: no effect.
- Hold outputs:
  - i_hold = i_req and not i_done.
  - d_hold = d_req and not d_done.
- rdata registers hold their value until the next completion for that side.
- Latency: with a zero-wait slave and 1-cycle read latency, a read issued in IDLE at cycle 0 has mem_read in cycle 1, readdatavalid in cycle 2, and done in cycle 3. Back-to-back transactions: one every 4 cycles (reads), 3 cycles (writes).
- Simultaneous i_req and d_req with counter < limit: D wins.
- The counter saturates at STARVE_LIMIT and never wraps.

Test Plan:
- Reset mid-read: reset_n low during WAIT_READ -> next cycle state IDLE, mem_read = 0, no done pulses, counter 0; a late mem_readdatavalid is ignored.
- Single fetch: i_req = 1, i_address = 0x100, slave zero-wait, data 0x80000000 one cycle later -> mem_read cycle 1 with address 0x100, i_done cycle 3 with i_rdata = 0x80000000, i_hold low in cycle 3.
- Store with waits: d_req = 1, d_write = 1, address 0x40, wdata 0xDEADBEEF, waitrequest high 3 cycles -> mem_write, address and data stable 4 cycles, d_done exactly 1 cycle after acceptance, d_rdata unchanged.
- Contention and starvation, STARVE_LIMIT = 4: i_req and d_req held continuously, d_req re-raised after each d_done -> grant order D, D, D, D, I, D...
- Cancel: fetch in WAIT_READ, i_cancel pulse, readdatavalid 2 cycles later -> no i_done, i_rdata updated, next IDLE serves the new i_address.
- Simultaneous requests from IDLE with counter 0 -> D served first, then I; no cycle has both mem_read and mem_write high.

Source files
------------

// File: rtl/memory_port_arbiter.sv
// memory_port_arbiter: shares one Avalon-style memory master between fetch (I) and data (D), D first with an I anti-starvation limit
module memory_port_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        i_req,
   input  logic [31:0] i_address,
   input  logic        i_cancel,
   output logic        i_hold,
   output logic        i_done,
   output logic [31:0] i_rdata,
   input  logic        d_req,
   input  logic        d_write,
   input  logic [31:0] d_address,
   input  logic [31:0] d_wdata,
   output logic        d_hold,
   output logic        d_done,
   output logic [31:0] d_rdata,
   output logic        mem_read,
   output logic        mem_write,
   output logic [31:0] mem_address,
   output logic [31:0] mem_writedata,
   input  logic        mem_waitrequest,
   input  logic [31:0] mem_readdata,
   input  logic        mem_readdatavalid
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_READ, DONE} state_t;
   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
   state_t state_q, state_d;
   logic own_q, own_d, write_q, write_d, cancel_q, cancel_d;
   logic [3:0] cnt_q, cnt_d;
   logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
   logic [31:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
   logic grant_d, grant_i;
   assign grant_d = d_req && (!i_req || cnt_q < LIMIT);
   assign grant_i = !grant_d && i_req && !i_cancel;
   always_comb begin
      state_d   = state_q;
      own_d     = own_q;
      write_d   = write_q;
      cancel_d  = cancel_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      i_rdata_d = i_rdata_q;
      d_rdata_d = d_rdata_q;
      case (state_q)
         IDLE: begin
            if (grant_d || grant_i) begin
               state_d = ISSUE;
               own_d   = grant_d;
               addr_d  = grant_d ? d_address : i_address;
               write_d = grant_d && d_write;
               wdata_d = d_wdata;
               cnt_d   = (grant_d && i_req) ? cnt_q + 4'd1 : 4'd0;
            end
         end
         ISSUE: begin
            if (!mem_waitrequest) state_d = write_q ? DONE : WAIT_READ;
            if (!own_q && i_cancel) cancel_d = 1'b1;
         end
         WAIT_READ: begin
            if (mem_readdatavalid) begin
               state_d   = DONE;
               i_rdata_d = own_q ? i_rdata_q : mem_readdata;
               d_rdata_d = own_q ? mem_readdata : d_rdata_q;
            end
            if (!own_q && i_cancel) cancel_d = 1'b1;
         end
         DONE: begin
            state_d  = IDLE;
            cancel_d = 1'b0;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         own_q     <= 1'b0;
         write_q   <= 1'b0;
         cancel_q  <= 1'b0;
         cnt_q     <= 4'd0;
         addr_q    <= 32'd0;
         wdata_q   <= 32'd0;
         i_rdata_q <= 32'd0;
         d_rdata_q <= 32'd0;
      end else begin
         state_q   <= state_d;
         own_q     <= own_d;
         write_q   <= write_d;
         cancel_q  <= cancel_d;
         cnt_q     <= cnt_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         i_rdata_q <= i_rdata_d;
         d_rdata_q <= d_rdata_d;
      end
   end
   // a cancelled fetch still completes on the bus but never reports done
   assign i_done        = (state_q == DONE) && !own_q && !cancel_q;
   assign d_done        = (state_q == DONE) && own_q;
   assign i_hold        = i_req && !i_done;
   assign d_hold        = d_req && !d_done;
   assign i_rdata       = i_rdata_q;
   assign d_rdata       = d_rdata_q;
   assign mem_read      = (state_q == ISSUE) && !write_q;
   assign mem_write     = (state_q == ISSUE) && write_q;
   assign mem_address   = addr_q;
   assign mem_writedata = wdata_q;
endmodule

// File: tb/tb_memory_port_arbiter.sv
// tb_memory_port_arbiter: directed and randomized checks of memory_port_arbiter against a transaction-level model
module tb_memory_port_arbiter;
   localparam int LIM = 4;
   logic clock = 1'b0, reset_n = 1'b0;
   logic i_req = 1'b0, i_cancel = 1'b0, d_req = 1'b0, d_write = 1'b0;
   logic [31:0] i_address = '0, d_address = '0, d_wdata = '0;
   logic i_hold, i_done, d_hold, d_done, mem_read, mem_write;
   logic [31:0] i_rdata, d_rdata, mem_address, mem_writedata;
   logic mem_waitrequest = 1'b1, mem_readdatavalid = 1'b0;
   logic [31:0] mem_readdata = '0;
   int vectors = 0, errors = 0;
   int cfg_ws = 0, cfg_lat = 1;
   bit rand_slave = 1'b0;
   int both_cnt = 0;
   logic [31:0] acc_addr = '0, acc_wdata = '0;
   logic acc_wr = 1'b0;

   always #5 clock = ~clock;

   memory_port_arbiter #(.STARVE_LIMIT(LIM)) dut (
      .clock(clock), .reset_n(reset_n),
      .i_req(i_req), .i_address(i_address), .i_cancel(i_cancel),
      .i_hold(i_hold), .i_done(i_done), .i_rdata(i_rdata),
      .d_req(d_req), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
      .d_hold(d_hold), .d_done(d_done), .d_rdata(d_rdata),
      .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
      .mem_writedata(mem_writedata), .mem_waitrequest(mem_waitrequest),
      .mem_readdata(mem_readdata), .mem_readdatavalid(mem_readdatavalid)
   );

   function automatic logic [31:0] rd_fn(input logic [31:0] a);
      return a ^ 32'h8000_0100;
   endfunction

   // Avalon slave: configurable wait states and read latency, logs each accepted command
   initial begin
      bit in_strobe;
      int ws_left, lat_left;
      logic [31:0] rd_val;
      in_strobe = 0; ws_left = 0; lat_left = 0; rd_val = '0;
      forever begin
         @(negedge clock);
         mem_readdatavalid = 1'b0;
         if (!reset_n) in_strobe = 0;
         if (lat_left > 0) begin
            lat_left--;
            if (lat_left == 0) begin
               mem_readdatavalid = 1'b1;
               mem_readdata = rd_val;
            end
         end
         if (mem_read && mem_write) both_cnt++;
         if (reset_n && (mem_read || mem_write)) begin
            if (!in_strobe) begin
               in_strobe = 1;
               ws_left = rand_slave ? int'($urandom_range(0, 3)) : cfg_ws;
            end
            if (ws_left == 0) begin
               mem_waitrequest = 1'b0;
               in_strobe = 0;
               acc_addr = mem_address;
               acc_wr = mem_write;
               acc_wdata = mem_writedata;
               if (mem_read) begin
                  lat_left = rand_slave ? int'($urandom_range(1, 3)) : cfg_lat;
                  rd_val = rd_fn(mem_address);
               end
            end else begin
               mem_waitrequest = 1'b1;
               ws_left--;
            end
         end else mem_waitrequest = 1'b1;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset;
      reset_n = 1'b0; i_req = 0; d_req = 0; i_cancel = 0; d_write = 0;
      tick; tick;
      reset_n = 1'b1;
   endtask

   task automatic wait_done(input bit side_d, output bit ok);
      ok = 0;
      for (int k = 0; k < 40 && !ok; k++) begin
         tick;
         ok = side_d ? d_done : i_done;
      end
   endtask

   task automatic test_reset;
      reset_n = 1'b0; i_req = 1; d_req = 0;
      tick; tick; #1;
      vectors++;
      if ({mem_read, mem_write, i_done, d_done} !== 4'b0) begin
         errors++; $display("FAIL reset_flags: got %b required 0000", {mem_read, mem_write, i_done, d_done});
      end
      vectors++;
      if (mem_address !== 0 || mem_writedata !== 0 || i_rdata !== 0 || d_rdata !== 0) begin
         errors++; $display("FAIL reset_data: addr %h wdata %h ird %h drd %h required 0", mem_address, mem_writedata, i_rdata, d_rdata);
      end
      vectors++;
      if (i_hold !== 1'b1 || d_hold !== 1'b0) begin
         errors++; $display("FAIL reset_hold_i: got i_hold %b d_hold %b required 1 0", i_hold, d_hold);
      end
      i_req = 0; d_req = 1; #1;
      vectors++;
      if (i_hold !== 1'b0 || d_hold !== 1'b1) begin
         errors++; $display("FAIL reset_hold_d: got i_hold %b d_hold %b required 0 1", i_hold, d_hold);
      end
      d_req = 0;
      tick;
      reset_n = 1'b1;
   endtask

   task automatic test_single_fetch;
      do_reset; cfg_ws = 0; cfg_lat = 1;
      i_req = 1; i_address = 32'h100; #1;
      vectors++;
      if (mem_read !== 1'b0 || i_hold !== 1'b1) begin
         errors++; $display("FAIL fetch_c0: mem_read %b i_hold %b required 0 1", mem_read, i_hold);
      end
      tick;
      vectors++;
      if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_address !== 32'h100) begin
         errors++; $display("FAIL fetch_c1: mem_read %b addr %h required 1 00000100", mem_read, mem_address);
      end
      tick;
      vectors++;
      if (mem_read !== 1'b0 || i_done !== 1'b0) begin
         errors++; $display("FAIL fetch_c2: mem_read %b i_done %b required 0 0", mem_read, i_done);
      end
      tick;
      vectors++;
      if (i_done !== 1'b1 || i_rdata !== 32'h8000_0000 || i_hold !== 1'b0) begin
         errors++; $display("FAIL fetch_c3: i_done %b i_rdata %h i_hold %b required 1 80000000 0", i_done, i_rdata, i_hold);
      end
      i_req = 0;
      tick;
      vectors++;
      if (i_done !== 1'b0 || i_rdata !== 32'h8000_0000) begin
         errors++; $display("FAIL fetch_c4: i_done %b i_rdata %h required 0 80000000", i_done, i_rdata);
      end
   endtask

   task automatic test_store_waits;
      bit ok;
      logic [31:0] ld;
      do_reset; cfg_ws = 0; cfg_lat = 1;
      d_req = 1; d_write = 0; d_address = 32'h44;
      wait_done(1'b1, ok);
      ld = rd_fn(32'h44);
      vectors++;
      if (!ok || d_rdata !== ld) begin
         errors++; $display("FAIL store_preload: done %b d_rdata %h required 1 %h", ok, d_rdata, ld);
      end
      d_req = 0;
      tick;
      cfg_ws = 3; d_req = 1; d_write = 1; d_address = 32'h40; d_wdata = 32'hDEAD_BEEF;
      for (int k = 1; k <= 4; k++) begin
         tick;
         vectors++;
         if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_address !== 32'h40 || mem_writedata !== 32'hDEAD_BEEF || d_done !== 1'b0) begin
            errors++; $display("FAIL store_hold_%0d: wr %b rd %b addr %h data %h done %b required 1 0 00000040 deadbeef 0", k, mem_write, mem_read, mem_address, mem_writedata, d_done);
         end
      end
      tick;
      vectors++;
      if (d_done !== 1'b1 || mem_write !== 1'b0 || d_rdata !== ld || d_hold !== 1'b0) begin
         errors++; $display("FAIL store_done: done %b wr %b d_rdata %h hold %b required 1 0 %h 0", d_done, mem_write, d_rdata, d_hold, ld);
      end
      d_req = 0;
      tick;
      vectors++;
      if (d_done !== 1'b0 || d_rdata !== ld) begin
         errors++; $display("FAIL store_after: done %b d_rdata %h required 0 %h", d_done, d_rdata, ld);
      end
   endtask

   task automatic test_starvation;
      logic [5:0] got;
      int n, b0;
      do_reset; cfg_ws = 0; cfg_lat = 1;
      b0 = both_cnt; got = '0; n = 0;
      i_req = 1; i_address = 32'h200; d_req = 1; d_write = 0; d_address = 32'h300;
      for (int k = 0; k < 80 && n < 6; k++) begin
         tick;
         if (d_done) begin got[n] = 1'b1; n++; d_address = d_address + 32'd4; end
         else if (i_done) begin got[n] = 1'b0; n++; end
      end
      vectors++;
      if (n != 6 || got !== 6'b101111) begin
         errors++; $display("FAIL starve_order: got %b (%0d grants) required 101111 (6)", got, n);
      end
      vectors++;
      if (both_cnt != b0) begin
         errors++; $display("FAIL starve_strobes: both strobes seen %0d times required 0", both_cnt - b0);
      end
      i_req = 0; d_req = 0;
      tick; tick; tick; tick;
   endtask

   task automatic test_cancel;
      bit ok;
      do_reset; cfg_ws = 0; cfg_lat = 3;
      i_req = 1; i_address = 32'h300;
      tick;
      vectors++;
      if (mem_read !== 1'b1 || mem_address !== 32'h300) begin
         errors++; $display("FAIL cancel_issue: rd %b addr %h required 1 00000300", mem_read, mem_address);
      end
      tick;
      i_cancel = 1; i_address = 32'h400;
      tick;
      i_cancel = 0;
      tick; tick;
      vectors++;
      if (i_done !== 1'b0 || i_rdata !== rd_fn(32'h300) || i_hold !== 1'b1) begin
         errors++; $display("FAIL cancel_done: i_done %b i_rdata %h i_hold %b required 0 %h 1", i_done, i_rdata, i_hold, rd_fn(32'h300));
      end
      tick;
      vectors++;
      if (mem_read !== 1'b0 || i_done !== 1'b0) begin
         errors++; $display("FAIL cancel_idle: rd %b done %b required 0 0", mem_read, i_done);
      end
      tick;
      vectors++;
      if (mem_read !== 1'b1 || mem_address !== 32'h400) begin
         errors++; $display("FAIL cancel_refetch: rd %b addr %h required 1 00000400", mem_read, mem_address);
      end
      wait_done(1'b0, ok);
      vectors++;
      if (!ok || i_rdata !== rd_fn(32'h400)) begin
         errors++; $display("FAIL cancel_newdata: done %b i_rdata %h required 1 %h", ok, i_rdata, rd_fn(32'h400));
      end
      i_req = 0;
      tick;
   endtask

   task automatic test_simultaneous;
      bit ok;
      int b0;
      do_reset; cfg_ws = int'($urandom_range(0, 2)); cfg_lat = 1;
      b0 = both_cnt;
      d_req = 1; d_write = 0; d_address = 32'h500; i_req = 1; i_address = 32'h600;
      tick;
      vectors++;
      if (mem_read !== 1'b1 || mem_address !== 32'h500) begin
         errors++; $display("FAIL simul_first: rd %b addr %h required 1 00000500", mem_read, mem_address);
      end
      wait_done(1'b1, ok);
      vectors++;
      if (!ok || d_rdata !== rd_fn(32'h500) || i_done !== 1'b0) begin
         errors++; $display("FAIL simul_d: done %b d_rdata %h i_done %b required 1 %h 0", ok, d_rdata, i_done, rd_fn(32'h500));
      end
      d_req = 0;
      wait_done(1'b0, ok);
      vectors++;
      if (!ok || i_rdata !== rd_fn(32'h600)) begin
         errors++; $display("FAIL simul_i: done %b i_rdata %h required 1 %h", ok, i_rdata, rd_fn(32'h600));
      end
      i_req = 0;
      vectors++;
      if (both_cnt != b0) begin
         errors++; $display("FAIL simul_strobes: both strobes seen %0d times required 0", both_cnt - b0);
      end
      tick;
   endtask

   task automatic test_reset_mid_read;
      bit ok;
      int n;
      do_reset; cfg_ws = 0; cfg_lat = 3;
      d_req = 1; d_write = 0; d_address = 32'h700; i_req = 1; i_address = 32'h800;
      n = 0;
      for (int k = 0; k < 100 && n < 4; k++) begin
         tick;
         if (d_done) n++;
      end
      ok = 0;
      for (int k = 0; k < 10 && !ok; k++) begin
         tick;
         ok = mem_read && mem_address == 32'h800;
      end
      vectors++;
      if (!ok || n != 4) begin
         errors++; $display("FAIL rst_setup: d grants %0d fetch issued %b required 4 1", n, ok);
      end
      tick;
      reset_n = 0; i_req = 0; d_req = 0;
      tick;
      reset_n = 1;
      for (int k = 0; k < 4; k++) begin
         vectors++;
         if ({mem_read, mem_write, i_done, d_done} !== 4'b0 || i_rdata !== 0 || d_rdata !== 0) begin
            errors++; $display("FAIL rst_quiet_%0d: flags %b ird %h drd %h required 0000 0 0", k, {mem_read, mem_write, i_done, d_done}, i_rdata, d_rdata);
         end
         tick;
      end
      d_req = 1; d_address = 32'h900; i_req = 1; i_address = 32'hA00;
      tick;
      vectors++;
      if (mem_read !== 1'b1 || mem_address !== 32'h900) begin
         errors++; $display("FAIL rst_counter: rd %b addr %h required 1 00000900", mem_read, mem_address);
      end
      i_req = 0;
      wait_done(1'b1, ok);
      d_req = 0;
      tick;
   endtask

   task automatic test_random;
      bit busy, own, e_wr, gd, done_now;
      int starve, bcnt;
      logic [31:0] e_addr, e_wdata, exp_i_rd, exp_d_rd;
      do_reset;
      rand_slave = 1;
      busy = 0; own = 0; e_wr = 0; starve = 0; bcnt = 0;
      e_addr = '0; e_wdata = '0; exp_i_rd = '0; exp_d_rd = '0;
      for (int c = 0; c < 3000; c++) begin
         tick;
         done_now = i_done || d_done;
         if (done_now) begin
            vectors++;
            if (!busy || d_done !== own || i_done === d_done) begin
               errors++; $display("FAIL rand_owner@%0d: i_done %b d_done %b busy %b required owner_d %b", c, i_done, d_done, busy, own);
            end else begin
               if (!e_wr) begin
                  if (own) exp_d_rd = rd_fn(e_addr);
                  else exp_i_rd = rd_fn(e_addr);
               end
               vectors++;
               if (acc_addr !== e_addr || acc_wr !== e_wr || (e_wr && acc_wdata !== e_wdata)) begin
                  errors++; $display("FAIL rand_cmd@%0d: addr %h wr %b data %h required %h %b %h", c, acc_addr, acc_wr, acc_wdata, e_addr, e_wr, e_wdata);
               end
            end
            vectors++;
            if (i_rdata !== exp_i_rd || d_rdata !== exp_d_rd) begin
               errors++; $display("FAIL rand_rdata@%0d: i %h d %h required %h %h", c, i_rdata, d_rdata, exp_i_rd, exp_d_rd);
            end
            busy = 0;
            if (d_done) begin
               d_req = 1'($urandom_range(0, 1)); d_write = 1'($urandom);
               d_address = $urandom; d_wdata = $urandom;
            end
            if (i_done) begin
               i_req = 1'($urandom_range(0, 1)); i_address = $urandom;
            end
         end else begin
            if (busy && ++bcnt > 40) begin
               vectors++; errors++;
               $display("FAIL rand_timeout@%0d: no done after %0d cycles required <= 40", c, bcnt);
               break;
            end
            if (!i_req && $urandom_range(0, 3) == 0) begin
               i_req = 1; i_address = $urandom;
            end
            if (!d_req && $urandom_range(0, 3) == 0) begin
               d_req = 1; d_write = 1'($urandom); d_address = $urandom; d_wdata = $urandom;
            end
         end
         #1;
         vectors++;
         if (i_hold !== (i_req && !i_done) || d_hold !== (d_req && !d_done)) begin
            errors++; $display("FAIL rand_hold@%0d: i_hold %b d_hold %b required %b %b", c, i_hold, d_hold, i_req && !i_done, d_req && !d_done);
         end
         if (!busy && !done_now && (i_req || d_req)) begin
            gd = d_req && (!i_req || starve < LIM);
            starve = (gd && i_req) ? starve + 1 : 0;
            busy = 1; bcnt = 0; own = gd;
            e_addr = gd ? d_address : i_address;
            e_wr = gd && d_write;
            e_wdata = d_wdata;
         end
      end
      i_req = 0; d_req = 0;
      rand_slave = 0;
   endtask

   initial begin
      int b0;
      b0 = both_cnt;
      test_reset;
      test_single_fetch;
      test_store_waits;
      test_starvation;
      test_cancel;
      test_simultaneous;
      test_reset_mid_read;
      test_random;
      vectors++;
      if (both_cnt != b0) begin
         errors++; $display("FAIL global_strobes: both strobes seen %0d times required 0", both_cnt - b0);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
